// File: rtl/serial_cmp_pkg.sv
// Shared types and constants for the bit-serial magnitude comparator.
package serial_cmp_pkg;

  localparam int MAX_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Bit-counter width, never narrower than one bit (WIDTH=1 still needs a counter).
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/cmp_bit1.sv
// Combinational 1-bit magnitude compare of a single bit pair.
module cmp_bit1 (
  input  logic a,
  input  logic b,
  output logic eq,
  output logic big_a,
  output logic big_b
);

  assign eq    = ~(a ^ b);
  assign big_a = a & ~b;
  assign big_b = ~a & b;

endmodule

// File: rtl/serial_cmp_seq.sv
// Bit-serial magnitude comparator, MSB first, one bit pair per clock.
// Build option SERIAL_CMP_EARLY_EXIT_EN: finish on the first differing bit pair.
//
// state | meaning
// IDLE  | ready for an operand pair
// SHIFT | one bit pair compared per cycle, first difference latched
// DONE  | result presented until out_ready
module serial_cmp_seq
  import serial_cmp_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = cnt_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             eq,
  output logic             neq,
  output logic             big_a,
  output logic             big_b,
  output logic             busy
);

  state_t state_q, state_d;

  logic [WIDTH-1:0] sa, sb;
  logic [CNT_W-1:0] cnt;
  logic             decided;
  logic             big_a_l, big_b_l;

  logic bit_eq, bit_big_a, bit_big_b;
  logic first_diff, last_bit, finish;
  logic res_decided, res_big_a, res_big_b;

  cmp_bit1 u_cmp_bit1 (
    .a     (sa[WIDTH-1]),
    .b     (sb[WIDTH-1]),
    .eq    (bit_eq),
    .big_a (bit_big_a),
    .big_b (bit_big_b)
  );

  assign first_diff = !decided && !bit_eq;
  assign last_bit   = (cnt == '0);

`ifdef SERIAL_CMP_EARLY_EXIT_EN
  assign finish = last_bit || first_diff;
`else
  assign finish = last_bit;
`endif

  // Result as it stands after this cycle's bit pair; first difference wins.
  assign res_decided = decided || first_diff;
  assign res_big_a   = decided ? big_a_l : bit_big_a;
  assign res_big_b   = decided ? big_b_l : bit_big_b;

  assign in_ready = (state_q == IDLE);
  assign busy     = (state_q == SHIFT) || (state_q == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = SHIFT;
      SHIFT:   if (finish) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa        <= '0;
      sb        <= '0;
      cnt       <= '0;
      decided   <= 1'b0;
      big_a_l   <= 1'b0;
      big_b_l   <= 1'b0;
      out_valid <= 1'b0;
      eq        <= 1'b0;
      neq       <= 1'b0;
      big_a     <= 1'b0;
      big_b     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            sa      <= a;
            sb      <= b;
            cnt     <= CNT_W'(WIDTH - 1);
            decided <= 1'b0;
            big_a_l <= 1'b0;
            big_b_l <= 1'b0;
          end
        end
        SHIFT: begin
          if (first_diff) begin
            big_a_l <= bit_big_a;
            big_b_l <= bit_big_b;
            decided <= 1'b1;
          end
          sa  <= sa << 1;
          sb  <= sb << 1;
          cnt <= cnt - 1'b1;
          if (finish) begin
            out_valid <= 1'b1;
            eq        <= !res_decided;
            neq       <= res_decided;
            big_a     <= res_big_a;
            big_b     <= res_big_b;
          end
        end
        DONE: begin
          // Flags are left as-is after the handshake; consumers qualify with out_valid.
          if (out_ready) out_valid <= 1'b0;
        end
        default: out_valid <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_cmp_seq.sv
// Self-checking bench: WIDTH=8 and WIDTH=1 comparators against an arithmetic reference.
module tb_serial_cmp_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic       in_valid8 = 1'b0, out_ready8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       in_ready8, out_valid8, eq8, neq8, big_a8, big_b8, busy8;

  logic       in_valid1 = 1'b0, out_ready1 = 1'b0;
  logic [0:0] a1 = '0, b1 = '0;
  logic       in_ready1, out_valid1, eq1, neq1, big_a1, big_b1, busy1;

  logic sel1 = 1'b0;
  int   n_assert = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  serial_cmp_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .out_valid(out_valid8), .out_ready(out_ready8),
    .eq(eq8), .neq(neq8), .big_a(big_a8), .big_b(big_b8), .busy(busy8)
  );

  serial_cmp_seq #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .out_valid(out_valid1), .out_ready(out_ready1),
    .eq(eq1), .neq(neq1), .big_a(big_a1), .big_b(big_b1), .busy(busy1)
  );

  wire c_in_ready  = sel1 ? in_ready1  : in_ready8;
  wire c_out_valid = sel1 ? out_valid1 : out_valid8;
  wire c_eq        = sel1 ? eq1        : eq8;
  wire c_neq       = sel1 ? neq1       : neq8;
  wire c_big_a     = sel1 ? big_a1     : big_a8;
  wire c_big_b     = sel1 ? big_b1     : big_b8;
  wire c_busy      = sel1 ? busy1      : busy8;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_in(input logic v, input logic [31:0] av, input logic [31:0] bv);
    if (sel1) begin
      in_valid1 = v; a1 = av[0:0]; b1 = bv[0:0];
    end else begin
      in_valid8 = v; a8 = av[7:0]; b8 = bv[7:0];
    end
  endtask

  task automatic drive_or(input logic v);
    if (sel1) out_ready1 = v;
    else      out_ready8 = v;
  endtask

  // Reference latency, counted in clock edges from the accepting edge (inclusive)
  // to the edge after which out_valid is seen high.
  function automatic int exp_latency(input int w, input logic [31:0] av, input logic [31:0] bv);
`ifdef SERIAL_CMP_EARLY_EXIT_EN
    for (int i = w - 1; i >= 0; i--)
      if (av[i] != bv[i]) return (w - i) + 1;
`endif
    return w + 1;
  endfunction

  // One full transaction; called just after a rising edge with the DUT in IDLE.
  task automatic xact(input int w, input logic [31:0] av_in, input logic [31:0] bv_in, input int hold);
    logic [31:0] mask, av, bv;
    logic        e_eq, e_ga, e_gb;
    int          lat;
    sel1 = (w == 1);
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 1);
    av = av_in & mask;
    bv = bv_in & mask;
    e_eq = (av == bv);
    e_ga = (av > bv);
    e_gb = (bv > av);

    check("idle_in_ready", {31'd0, c_in_ready}, 32'd1);
    drive_in(1'b1, av, bv);
    @(posedge clk); #1;
    drive_in(1'b0, ~av, ~bv);
    lat = 1;
    check("accept_busy", {31'd0, c_busy}, 32'd1);
    check("accept_in_ready", {31'd0, c_in_ready}, 32'd0);
    while (!c_out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", lat, exp_latency(w, av, bv));
    check("eq", {31'd0, c_eq}, {31'd0, e_eq});
    check("neq", {31'd0, c_neq}, {31'd0, !e_eq});
    check("big_a", {31'd0, c_big_a}, {31'd0, e_ga});
    check("big_b", {31'd0, c_big_b}, {31'd0, e_gb});

    for (int h = 0; h < hold; h++) begin
      drive_in(1'b1, $urandom, $urandom);
      @(posedge clk); #1;
      check("bp_out_valid", {31'd0, c_out_valid}, 32'd1);
      check("bp_in_ready", {31'd0, c_in_ready}, 32'd0);
      check("bp_flags", {28'd0, c_eq, c_neq, c_big_a, c_big_b}, {28'd0, e_eq, !e_eq, e_ga, e_gb});
    end

    // Handshake cycle with a competing in_valid that must be ignored.
    drive_or(1'b1);
    drive_in(1'b1, $urandom, $urandom);
    @(posedge clk); #1;
    drive_or(1'b0);
    drive_in(1'b0, 32'd0, 32'd0);
    check("hs_out_valid", {31'd0, c_out_valid}, 32'd0);
    check("hs_idle", {30'd0, c_in_ready, c_busy}, 32'b10);
    check("hs_flags_kept", {28'd0, c_eq, c_neq, c_big_a, c_big_b}, {28'd0, e_eq, !e_eq, e_ga, e_gb});
  endtask

  initial begin
    #3;
    check("rst_outs8", {26'd0, out_valid8, eq8, neq8, big_a8, big_b8, busy8}, 32'd0);
    check("rst_in_ready8", {31'd0, in_ready8}, 32'd1);
    check("rst_in_ready1", {31'd0, in_ready1}, 32'd1);
    #9 rst_n = 1'b1;
    @(posedge clk); #1;

    xact(8, 32'hA5, 32'hA5, 0);
    xact(8, 32'h80, 32'h7F, 5);
    xact(8, 32'h01, 32'h03, 1);

    // Abort in the third SHIFT cycle.
    sel1 = 1'b0;
    drive_in(1'b1, 32'hFF, 32'h00);
    @(posedge clk); #1;
    drive_in(1'b0, 32'h00, 32'h00);
    repeat (2) begin @(posedge clk); #1; end
    check("pre_abort_busy", {31'd0, busy8}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_outs", {26'd0, out_valid8, eq8, neq8, big_a8, big_b8, busy8}, 32'd0);
    check("abort_in_ready", {31'd0, in_ready8}, 32'd1);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_abort_idle", {30'd0, in_ready8, out_valid8}, 32'b10);
    xact(8, 32'h10, 32'h20, 1);

    xact(1, 32'd1, 32'd0, 0);
    xact(1, 32'd1, 32'd1, 2);
    xact(1, 32'd0, 32'd1, 0);

    for (int i = 0; i < 24; i++) begin
      logic [31:0] ra, rb;
      int          w;
      w  = ($urandom_range(0, 4) == 0) ? 1 : 8;
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
      xact(w, ra, rb, $urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
